// File: rtl/vseq_pkg.sv
// Shared definitions for the vector memory sequencer: FSM state encoding,
// lane-index width helper and the byte order used to map lanes onto vectors.
package vseq_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LD_RD   = 3'd1,
        LD_LAST = 3'd2,
        LD_WB   = 3'd3,
        ST_WR   = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    // Lane 0 occupies the most significant byte of a vector and the MSB T-register strobe.
    localparam bit LANE0_IS_MSB = 1'b1;

    function automatic int lane_w(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/vseq_addr_gen.sv
// Address generator: latches base (and stride when VSEQ_STRIDE_EN is defined)
// at accept, then advances the address by one stride per lane step.
module vseq_addr_gen
    import vseq_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int ADDR_W    = 8,
    parameter int LANE_W    = lane_w(NUM_LANES)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] base_addr,
`ifdef VSEQ_STRIDE_EN
    input  logic [ADDR_W-1:0] stride,
`endif
    output logic [ADDR_W-1:0] addr,
    output logic [LANE_W-1:0] lane
);

`ifdef VSEQ_STRIDE_EN
    logic [ADDR_W-1:0] stride_q;
`endif

    // Address accumulates one stride per lane, so no multiplier is needed and wrap is free.
    always_ff @(posedge clock) begin
        if (reset) begin
            addr     <= '0;
            lane     <= '0;
`ifdef VSEQ_STRIDE_EN
            stride_q <= '0;
`endif
        end else if (load) begin
            addr     <= base_addr;
            lane     <= '0;
`ifdef VSEQ_STRIDE_EN
            stride_q <= stride;
`endif
        end else if (step) begin
`ifdef VSEQ_STRIDE_EN
            addr     <= addr + stride_q;
`else
            addr     <= addr + ADDR_W'(1);
`endif
            lane     <= lane + LANE_W'(1);
        end
    end

endmodule

// File: rtl/vector_mem_sequencer.sv
// Sequences vload/vstore byte transfers between data memory and the vector datapath.
// Optional macro VSEQ_STRIDE_EN adds a latched per-lane address stride input.
module vector_mem_sequencer
    import vseq_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    localparam int LANE_W   = lane_w(NUM_LANES)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        is_store,
    input  logic [ADDR_W-1:0]           base_addr,
    input  logic [NUM_LANES*DATA_W-1:0] x1_data,
`ifdef VSEQ_STRIDE_EN
    input  logic [ADDR_W-1:0]           stride,
`endif
    input  logic [DATA_W-1:0]           mem_q,
    output logic                        busy,
    output logic                        done,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic                        mem_read,
    output logic                        mem_write,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic [LANE_W-1:0]           lane_sel,
    output logic                        vout_sel,
    output logic [NUM_LANES-1:0]        t_ld,
    output logic                        vrf_write
);

    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

    state_t                        state, next_state;
    logic [NUM_LANES*DATA_W-1:0]   x1_q;
    logic [ADDR_W-1:0]             cur_addr;
    logic [LANE_W-1:0]             lane;
    logic                          accept, step;
    logic [DATA_W-1:0]             lane_byte;

    function automatic int lane_pos(input logic [LANE_W-1:0] l);
        return LANE0_IS_MSB ? (NUM_LANES - 1 - int'(l)) : int'(l);
    endfunction

    function automatic logic [NUM_LANES-1:0] lane_strobe(input logic [LANE_W-1:0] l);
        return NUM_LANES'(1) << lane_pos(l);
    endfunction

    assign accept    = (state == IDLE) && start;
    assign lane_byte = DATA_W'(x1_q >> (DATA_W * lane_pos(lane)));

    vseq_addr_gen #(
        .NUM_LANES (NUM_LANES),
        .ADDR_W    (ADDR_W)
    ) u_addr_gen (
        .clock     (clock),
        .reset     (reset),
        .load      (accept),
        .step      (step),
        .base_addr (base_addr),
`ifdef VSEQ_STRIDE_EN
        .stride    (stride),
`endif
        .addr      (cur_addr),
        .lane      (lane)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            x1_q  <= '0;
        end else begin
            state <= next_state;
            if (accept) x1_q <= x1_data;
        end
    end

    // NOTE: every output gets a default before the case so no path infers a latch.
    always_comb begin
        next_state = state;
        step       = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        mem_addr   = '0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_wdata  = '0;
        lane_sel   = '0;
        vout_sel   = 1'b0;
        t_ld       = '0;
        vrf_write  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) next_state = is_store ? ST_WR : LD_RD;
            end
            LD_RD: begin
                busy     = 1'b1;
                mem_read = 1'b1;
                mem_addr = cur_addr;
                step     = 1'b1;
                // Read data lags the address by one cycle, so lane k-1 is captured while lane k is read.
                if (lane != '0) begin
                    vout_sel = 1'b1;
                    t_ld     = lane_strobe(lane - LANE_W'(1));
                end
                if (lane == LAST_LANE) next_state = LD_LAST;
            end
            LD_LAST: begin
                busy       = 1'b1;
                vout_sel   = 1'b1;
                t_ld       = lane_strobe(LAST_LANE);
                next_state = LD_WB;
            end
            LD_WB: begin
                busy       = 1'b1;
                vrf_write  = 1'b1;
                done       = 1'b1;
                next_state = IDLE;
            end
            ST_WR: begin
                busy      = 1'b1;
                mem_write = 1'b1;
                mem_addr  = cur_addr;
                mem_wdata = lane_byte;
                lane_sel  = lane;
                step      = 1'b1;
                if (lane == LAST_LANE) next_state = ST_DONE;
            end
            ST_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        // Reset blanks the strobes in the cycle it is asserted, so an interrupted store writes nothing more.
        if (reset) begin
            step      = 1'b0;
            busy      = 1'b0;
            done      = 1'b0;
            mem_addr  = '0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            mem_wdata = '0;
            lane_sel  = '0;
            vout_sel  = 1'b0;
            t_ld      = '0;
            vrf_write = 1'b0;
        end
    end

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Self-checking bench for vector_mem_sequencer: directed cases plus random
// vload/vstore transfers against a per-cycle reference model and memory image.
module tb_vector_mem_sequencer;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 8;

    logic            clock = 1'b0;
    logic            reset;
    logic            start;
    logic            is_store;
    logic [AW-1:0]   base_addr;
    logic [N*DW-1:0] x1_data;
`ifdef VSEQ_STRIDE_EN
    logic [AW-1:0]   stride;
`endif
    logic [DW-1:0]   mem_q = '0;
    logic            busy, done, mem_read, mem_write, vout_sel, vrf_write;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [1:0]      lane_sel;
    logic [N-1:0]    t_ld;

    always #5 clock = ~clock;

    vector_mem_sequencer #(.NUM_LANES(N), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .is_store  (is_store),
        .base_addr (base_addr),
        .x1_data   (x1_data),
`ifdef VSEQ_STRIDE_EN
        .stride    (stride),
`endif
        .mem_q     (mem_q),
        .busy      (busy),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_wdata (mem_wdata),
        .lane_sel  (lane_sel),
        .vout_sel  (vout_sel),
        .t_ld      (t_ld),
        .vrf_write (vrf_write)
    );

    // Environment: single-port memory with registered read data and the datapath T registers.
    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    logic [7:0] t_reg   [N];

    always @(posedge clock) begin
        if (mem_write) mem[mem_addr] <= mem_wdata;
        if (mem_read)  mem_q <= mem[mem_addr];
        for (int i = 0; i < N; i++)
            if (vout_sel && t_ld[N-1-i]) t_reg[i] <= mem_q;
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] all_outputs();
        return {busy, done, mem_read, mem_write, vout_sel, vrf_write, t_ld, lane_sel, mem_addr, mem_wdata};
    endfunction

    task automatic run_txn(input bit st, input logic [7:0] base, input logic [31:0] x1,
                           input logic [7:0] strd, input bit hold);
        int         lat;
        bit         e_rd, e_wr, e_cap;
        logic [7:0] e_addr, e_wdata, a;
        logic [1:0] e_lsel;
        logic [3:0] e_tld;
        logic [31:0] e_word, t_word;
        lat       = st ? N + 1 : N + 2;
        start     = 1'b1;
        is_store  = st;
        base_addr = base;
        x1_data   = x1;
`ifdef VSEQ_STRIDE_EN
        stride    = strd;
`endif
        check("accept_hidden", all_outputs(), 0);
        for (int k = 1; k <= lat; k++) begin
            @(posedge clock); #1;
            if (k == 1 && !hold) start = 1'b0;
            if (k == 2) begin
                x1_data   = $urandom;
                base_addr = 8'($urandom);
                is_store  = 1'($urandom);
`ifdef VSEQ_STRIDE_EN
                stride    = 8'($urandom);
`endif
            end
            e_rd    = !st && k <= N;
            e_wr    = st && k <= N;
            e_cap   = !st && k >= 2 && k <= N + 1;
            e_addr  = (e_rd || e_wr) ? 8'(int'(base) + (k - 1) * int'(strd)) : 8'h00;
            e_wdata = e_wr ? x1[8*(N-k) +: 8] : 8'h00;
            e_lsel  = e_wr ? 2'(k - 1) : 2'd0;
            e_tld   = e_cap ? (4'b1000 >> (k - 2)) : 4'b0000;
            check($sformatf("ctl %s k%0d", st ? "st" : "ld", k),
                  {busy, done, mem_read, mem_write, vout_sel, vrf_write, t_ld, lane_sel},
                  {1'b1, k == lat, e_rd, e_wr, e_cap, !st && k == lat, e_tld, e_lsel});
            check($sformatf("addr_data %s k%0d", st ? "st" : "ld", k),
                  {mem_addr, mem_wdata}, {e_addr, e_wdata});
            if (e_wr) ref_mem[e_addr] = e_wdata;
        end
        @(posedge clock); #1;
        check("idle_after_done", all_outputs(), 0);
        if (!st) begin
            e_word = '0;
            for (int i = 0; i < N; i++) begin
                e_word = {e_word[23:0], ref_mem[8'(int'(base) + i * int'(strd))]};
                t_word = {t_word[23:0], t_reg[i]};
            end
            check("t_word", t_word, e_word);
        end else begin
            for (int i = 0; i < N; i++) begin
                a = 8'(int'(base) + i * int'(strd));
                check($sformatf("mem[%0h]", a), mem[a], ref_mem[a]);
            end
        end
    endtask

    task automatic reset_mid_store();
        start     = 1'b1;
        is_store  = 1'b1;
        base_addr = 8'h20;
        x1_data   = 32'h55667788;
`ifdef VSEQ_STRIDE_EN
        stride    = 8'd1;
`endif
        @(posedge clock); #1;
        start = 1'b0;
        check("rst_c1", {mem_write, mem_addr, mem_wdata}, {1'b1, 8'h20, 8'h55});
        ref_mem[8'h20] = 8'h55;
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        check("rst_c2_blanked", all_outputs(), 0);
        @(posedge clock); #1;
        reset = 1'b0;
        check("rst_c3_idle", all_outputs(), 0);
        @(posedge clock); #1;
        check("rst_c4_idle", all_outputs(), 0);
        for (int i = 0; i < N; i++)
            check($sformatf("rst_mem[%0h]", 8'h20 + i), mem[8'h20 + i], ref_mem[8'h20 + i]);
    endtask

    initial begin
        logic [7:0] strd;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        for (int i = 0; i < N; i++) begin
            mem[8'h10 + i]     = 8'hAA + 8'(i * 8'h11);
            ref_mem[8'h10 + i] = mem[8'h10 + i];
            t_reg[i]           = 8'h00;
        end
        reset     = 1'b1;
        start     = 1'b0;
        is_store  = 1'b0;
        base_addr = '0;
        x1_data   = '0;
`ifdef VSEQ_STRIDE_EN
        stride    = 8'd1;
`endif
        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs", all_outputs(), 0);
        reset = 1'b0;
        @(posedge clock); #1;
        check("idle_outputs", all_outputs(), 0);

        run_txn(1'b0, 8'h10, 32'h0, 8'd1, 1'b0);
        run_txn(1'b1, 8'h20, 32'h11223344, 8'd1, 1'b0);
        run_txn(1'b0, 8'hFE, 32'h0, 8'd1, 1'b0);
        run_txn(1'b1, 8'h30, 32'hA1B2C3D4, 8'd1, 1'b1);
        run_txn(1'b0, 8'h30, 32'h0, 8'd1, 1'b0);
        reset_mid_store();
`ifdef VSEQ_STRIDE_EN
        run_txn(1'b0, 8'h40, 32'h0, 8'd4, 1'b0);
        run_txn(1'b0, 8'h40, 32'h0, 8'd0, 1'b0);
        run_txn(1'b1, 8'h50, 32'hDEADBEEF, 8'd0, 1'b0);
`endif
        for (int n = 0; n < 24; n++) begin
            strd = 8'd1;
`ifdef VSEQ_STRIDE_EN
            case ($urandom_range(3))
                0: strd = 8'd0;
                1: strd = 8'd1;
                2: strd = 8'd4;
                default: strd = 8'($urandom);
            endcase
`endif
            run_txn(1'($urandom), 8'($urandom), $urandom, strd, (n != 23) && 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
